slice_sequencer: RTL and testbench
==================================

SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001 SHALL have parameter STEPS_PER_MM, default 16, meaning track-motor steps per mm of feed.
REQ-002 SHALL have parameter MEAS_TIMEOUT, default 1000000, meaning clock cycles allowed for a distance measurement.
REQ-003 SHALL have port clk  in  1  system clock; the single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  in  1  level; begin a slicing job.
REQ-006 SHALL have port pause_i  in  1  level; hold sequencing.
REQ-007 SHALL have port slice_len_i  in  8  slice thickness in mm, latched at job start.
REQ-008 SHALL have port slice_total_i  in  5  slices requested, latched at job start.
REQ-009 SHALL have port dist_valid_i  in  1  one-cycle pulse from the supersonic front end.
REQ-010 SHALL have port dist_i  in  9  remaining material length in mm, qualified by dist_valid_i.
REQ-011 SHALL have port move_req_o  out  1  request to the track step driver.
REQ-012 SHALL have port move_steps_o  out  16  step count for the current move.
REQ-013 SHALL have port move_done_i  in  1  one-cycle completion pulse from the track driver.
REQ-014 SHALL have port cut_req_o  out  1  request to the cut controller.
REQ-015 SHALL have port cut_done_i  in  1  one-cycle completion pulse from the cut controller.
REQ-016 SHALL have port slice_cnt_o  out  5  slices completed in the current job.
REQ-017 SHALL have port busy_o  out  1  high in MEAS, MOVE and CUT.
REQ-018 SHALL have port finish_o  out  1  job complete, level.
REQ-019 SHALL have port short_o  out  1  job ended because material ran out.
REQ-020 SHALL have port err_o  out  1  job aborted.

Function
REQ-021 SHALL implement the FSM states IDLE, MEAS, MOVE, CUT, FIN and ERR.
REQ-022 In IDLE, FIN or ERR, start_i=1 SHALL latch slice_len_i and slice_total_i, clear slice_cnt_o, finish_o, short_o and err_o, and enter MEAS on the next edge.
REQ-023 start_i SHALL be ignored in MEAS, MOVE and CUT.
REQ-024 At start, latched slice_len=0 SHALL take priority and enter ERR.
REQ-025 At start, latched slice_total=0 with nonzero slice_len SHALL enter FIN directly.
REQ-026 In MEAS, a cycle counter SHALL increment each unpaused cycle and clear on entry.
REQ-027 In MEAS, the counter reaching MEAS_TIMEOUT SHALL cause entry to ERR.
REQ-028 In MEAS, dist_valid_i with dist_i < slice_len SHALL cause entry to FIN with short_o=1.
REQ-029 In MEAS, dist_valid_i with dist_i >= slice_len SHALL load move_steps_o = slice_len*STEPS_PER_MM (16-bit, truncated) and enter MOVE.
REQ-030 move_steps_o SHALL hold its value until the next load.
REQ-031 Request handshake: the req output SHALL rise on the first cycle in its state with pause_i=0, stay high regardless of pause until the matching done, and fall the cycle after done.
REQ-032 A done pulse arriving while the matching req is low SHALL be ignored.
REQ-033 MOVE: move_done_i SHALL cause entry to CUT on the next edge.
REQ-034 CUT entry from MOVE: cut_req_o SHALL rise on the same edge that move_req_o falls, if pause_i=0.
REQ-035 CUT: cut_done_i SHALL increment slice_cnt_o on the next edge.
REQ-036 CUT: after cut_done_i, the FSM SHALL enter FIN if the new count equals slice_total, else MEAS.
REQ-037 Pause in MEAS: while pause_i=1, dist_valid_i SHALL be ignored and the timeout counter frozen.
REQ-038 Pause in other states: transitions SHALL not be blocked, and only req issuance per REQ-031 is gated.
REQ-039 finish_o SHALL be high in FIN.
REQ-040 err_o SHALL be high in ERR.
REQ-041 finish_o, err_o and short_o SHALL be held until the next accepted start_i.
REQ-042 All outputs SHALL be registered.

Reset
REQ-043 rst=1 SHALL force IDLE asynchronously and take effect immediately, also mid-job.
REQ-044 During reset, all outputs, move_steps_o, the latched config and the counters SHALL be 0.
REQ-045 Reset SHALL drop move_req_o and cut_req_o immediately.
REQ-046 After reset release, the block SHALL wait in IDLE for start_i.

Verification
REQ-047 slice_len=5, slice_total=3, dist_i=100 on each measure, done pulses 10 cycles after req -> move_steps_o=80, three MOVE/CUT pairs, slice_cnt_o 1,2,3, finish_o=1, short_o=0.
REQ-048 slice_len=20, slice_total=4, dist_i sequence 50,30,15 -> two slices done, finish_o=1, short_o=1, slice_cnt_o=2.
REQ-049 MEAS_TIMEOUT=100, no dist_valid_i -> err_o=1 after 100 unpaused cycles; with pause_i high for 50 cycles mid-wait -> err_o after 150 cycles.
REQ-050 pause_i=1 asserted on the edge move_done_i is seen -> CUT entered, cut_req_o stays 0 until pause_i=0, then rises the next cycle.
REQ-051 rst pulsed while cut_req_o=1 -> cut_req_o=0 and slice_cnt_o=0 immediately; a later start_i restarts from MEAS.
REQ-052 slice_total=0 -> FIN with finish_o=1 one cycle after start_i; slice_len=0 -> err_o=1 one cycle after start_i.

Source files
------------

// File: rtl/slice_sequencer.sv
// Slice sequencer: measure remaining stock, feed the track by one slice,
// cut, and repeat until the requested count is reached, the stock runs
// short, or the measurement times out.
module slice_sequencer #(
  parameter int STEPS_PER_MM = 16,
  parameter int MEAS_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic [7:0]  slice_len_i,
  input  logic [4:0]  slice_total_i,
  input  logic        dist_valid_i,
  input  logic [8:0]  dist_i,
  output logic        move_req_o,
  output logic [15:0] move_steps_o,
  input  logic        move_done_i,
  output logic        cut_req_o,
  input  logic        cut_done_i,
  output logic [4:0]  slice_cnt_o,
  output logic        busy_o,
  output logic        finish_o,
  output logic        short_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEAS, S_MOVE, S_CUT, S_FIN, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [4:0]  total_q, total_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] meas_q, meas_d;
  logic [15:0] steps_q, steps_d;
  logic        move_req_q, move_req_d;
  logic        cut_req_q, cut_req_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;
  logic        short_q, short_d;
  logic        err_q, err_d;
  logic [4:0]  cnt_inc;

  assign cnt_inc = cnt_q + 5'd1;

  // State and all registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
      meas_q     <= '0;
      steps_q    <= '0;
      move_req_q <= 1'b0;
      cut_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      short_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      meas_q     <= meas_d;
      steps_q    <= steps_d;
      move_req_q <= move_req_d;
      cut_req_q  <= cut_req_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      short_q    <= short_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    total_d  = total_q;
    cnt_d    = cnt_q;
    meas_d   = meas_q;
    steps_d  = steps_q;
    finish_d = finish_q;
    short_d  = short_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (start_i) begin
          len_d    = slice_len_i;
          total_d  = slice_total_i;
          cnt_d    = '0;
          meas_d   = '0;
          finish_d = 1'b0;
          short_d  = 1'b0;
          err_d    = 1'b0;
          // Zero thickness is a bad job; zero count is trivially done.
          if (slice_len_i == 8'd0) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (slice_total_i == 5'd0) begin
            state_d  = S_FIN;
            finish_d = 1'b1;
          end else begin
            state_d = S_MEAS;
          end
        end
      end
      S_MEAS: begin
        // Pause freezes both the timeout and measurement acceptance.
        if (!pause_i) begin
          if (dist_valid_i) begin
            if (dist_i < {1'b0, len_q}) begin
              state_d  = S_FIN;
              finish_d = 1'b1;
              short_d  = 1'b1;
            end else begin
              steps_d = 16'(32'(len_q) * 32'(STEPS_PER_MM));
              state_d = S_MOVE;
            end
          end else if (meas_q == 32'(MEAS_TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            meas_d = meas_q + 32'd1;
          end
        end
      end
      S_MOVE: begin
        if (move_done_i && move_req_q) state_d = S_CUT;
      end
      S_CUT: begin
        if (cut_done_i && cut_req_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == total_q) begin
            state_d  = S_FIN;
            finish_d = 1'b1;
          end else begin
            state_d = S_MEAS;
            meas_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request rises on the first unpaused cycle of its state and then
    // holds through pause until the state is left on its done pulse.
    move_req_d = (state_d == S_MOVE) && (move_req_q || !pause_i);
    cut_req_d  = (state_d == S_CUT)  && (cut_req_q  || !pause_i);
    busy_d     = (state_d == S_MEAS) || (state_d == S_MOVE) || (state_d == S_CUT);
  end

  assign move_req_o   = move_req_q;
  assign move_steps_o = steps_q;
  assign cut_req_o    = cut_req_q;
  assign slice_cnt_o  = cnt_q;
  assign busy_o       = busy_q;
  assign finish_o     = finish_q;
  assign short_o      = short_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Scenario bench for slice_sequencer with a queue scoreboard for step
// counts and slice counts.
module tb_slice_sequencer;

  localparam int SPM = 16;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        pause_i = 1'b0;
  logic [7:0]  slice_len_i = '0;
  logic [4:0]  slice_total_i = '0;
  logic        dist_valid_i = 1'b0;
  logic [8:0]  dist_i = '0;
  logic        move_req_o;
  logic [15:0] move_steps_o;
  logic        move_done_i = 1'b0;
  logic        cut_req_o;
  logic        cut_done_i = 1'b0;
  logic [4:0]  slice_cnt_o;
  logic        busy_o, finish_o, short_o, err_o;

  int vecs = 0;
  int errs = 0;
  int dist_seq[$];
  int exp_steps_q[$];
  int exp_cnt_q[$];

  slice_sequencer #(.STEPS_PER_MM(SPM), .MEAS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i),
    .slice_len_i(slice_len_i), .slice_total_i(slice_total_i),
    .dist_valid_i(dist_valid_i), .dist_i(dist_i),
    .move_req_o(move_req_o), .move_steps_o(move_steps_o), .move_done_i(move_done_i),
    .cut_req_o(cut_req_o), .cut_done_i(cut_done_i), .slice_cnt_o(slice_cnt_o),
    .busy_o(busy_o), .finish_o(finish_o), .short_o(short_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int total);
    slice_len_i   = 8'(len);
    slice_total_i = 5'(total);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_dist(input int d);
    dist_i = 9'(d);
    dist_valid_i = 1'b1;
    tick();
    dist_valid_i = 1'b0;
  endtask

  task automatic wait_req(input bit is_cut, input string nm);
    int n = 0;
    while (((is_cut ? cut_req_o : move_req_o) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    vecs++;
    if (n >= 50) begin
      errs++;
      $display("FAIL %s: req never rose within 50 cycles", nm);
    end
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({move_req_o, cut_req_o, busy_o, finish_o, short_o, err_o} !== 6'b0 ||
        move_steps_o !== 16'd0 || slice_cnt_o !== 5'd0) begin
      errs++;
      $display("FAIL reset_outputs: got req=%b/%b busy=%b fin=%b sh=%b err=%b steps=%0d cnt=%0d, want all 0",
               move_req_o, cut_req_o, busy_o, finish_o, short_o, err_o, move_steps_o, slice_cnt_o);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    vecs++;
    if (busy_o !== 1'b0 || finish_o !== 1'b0) begin
      errs++;
      $display("FAIL idle_wait: busy=%b finish=%b, want 0 0", busy_o, finish_o);
    end
  endtask

  // Full job driven from dist_seq; done pulses come 10 cycles after each req.
  task automatic test_job(input int len, input int total, input int exp_cnt, input bit exp_short);
    int  model_cnt = 0;
    bit  model_short = 0;
    int  d;
    start_job(len, total);
    vecs++;
    if (busy_o !== 1'b1) begin
      errs++;
      $display("FAIL job_busy: got %b want 1", busy_o);
    end
    while (model_cnt < total && !model_short) begin
      repeat (3) tick();
      d = (dist_seq.size() > 0) ? dist_seq.pop_front() : 0;
      if (d < len) model_short = 1;
      else exp_steps_q.push_back((len * SPM) & 16'hFFFF);
      pulse_dist(d);
      if (model_short) break;
      wait_req(1'b0, "move_req");
      vecs++;
      if (int'(move_steps_o) !== exp_steps_q[0]) begin
        errs++;
        $display("FAIL move_steps: got %0d want %0d", move_steps_o, exp_steps_q[0]);
      end
      void'(exp_steps_q.pop_front());
      repeat (10) tick();
      move_done_i = 1'b1;
      tick();
      move_done_i = 1'b0;
      vecs++;
      if (move_req_o !== 1'b0 || cut_req_o !== 1'b1) begin
        errs++;
        $display("FAIL move_to_cut: move_req=%b cut_req=%b, want 0 1", move_req_o, cut_req_o);
      end
      repeat (10) tick();
      cut_done_i = 1'b1;
      model_cnt++;
      exp_cnt_q.push_back(model_cnt);
      tick();
      cut_done_i = 1'b0;
      vecs++;
      if (int'(slice_cnt_o) !== exp_cnt_q[0]) begin
        errs++;
        $display("FAIL slice_cnt: got %0d want %0d", slice_cnt_o, exp_cnt_q[0]);
      end
      void'(exp_cnt_q.pop_front());
    end
    vecs++;
    if (finish_o !== 1'b1 || short_o !== exp_short || err_o !== 1'b0 ||
        busy_o !== 1'b0 || int'(slice_cnt_o) !== exp_cnt) begin
      errs++;
      $display("FAIL job_end: fin=%b sh=%b err=%b busy=%b cnt=%0d, want 1 %b 0 0 %0d",
               finish_o, short_o, err_o, busy_o, slice_cnt_o, exp_short, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    dist_seq = '{100, 100, 100};
    test_job(5, 3, 3, 1'b0);
    dist_seq = '{50, 30, 15};
    test_job(20, 4, 2, 1'b1);
  endtask

  task automatic test_timeout();
    start_job(5, 1);
    repeat (TO - 1) tick();
    vecs++;
    if (err_o !== 1'b0) begin
      errs++;
      $display("FAIL timeout_early: err=%b at %0d cycles, want 0", err_o, TO - 1);
    end
    tick();
    vecs++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL timeout: err=%b busy=%b, want 1 0", err_o, busy_o);
    end
    // Again with a 50-cycle pause mid-wait, and a measurement during pause.
    start_job(5, 1);
    repeat (30) tick();
    pause_i = 1'b1;
    pulse_dist(100);
    vecs++;
    if (move_req_o !== 1'b0 || busy_o !== 1'b1 || err_o !== 1'b0) begin
      errs++;
      $display("FAIL pause_meas: move_req=%b busy=%b err=%b, want 0 1 0", move_req_o, busy_o, err_o);
    end
    repeat (49) tick();
    pause_i = 1'b0;
    repeat (TO - 31) tick();
    vecs++;
    if (err_o !== 1'b0) begin
      errs++;
      $display("FAIL timeout_pause_early: err=%b, want 0", err_o);
    end
    tick();
    vecs++;
    if (err_o !== 1'b1) begin
      errs++;
      $display("FAIL timeout_pause: err=%b, want 1", err_o);
    end
  endtask

  task automatic test_pause_cut();
    start_job(3, 1);
    repeat (2) tick();
    pulse_dist(50);
    vecs++;
    if (move_req_o !== 1'b1 || move_steps_o !== 16'd48) begin
      errs++;
      $display("FAIL pause_move: req=%b steps=%0d, want 1 48", move_req_o, move_steps_o);
    end
    repeat (3) tick();
    move_done_i = 1'b1;
    pause_i = 1'b1;
    tick();
    move_done_i = 1'b0;
    repeat (4) tick();
    // Stray cut_done while cut_req is low must not count.
    cut_done_i = 1'b1;
    tick();
    cut_done_i = 1'b0;
    vecs++;
    if (cut_req_o !== 1'b0 || move_req_o !== 1'b0 || busy_o !== 1'b1 || slice_cnt_o !== 5'd0) begin
      errs++;
      $display("FAIL pause_cut_hold: cut=%b move=%b busy=%b cnt=%0d, want 0 0 1 0",
               cut_req_o, move_req_o, busy_o, slice_cnt_o);
    end
    pause_i = 1'b0;
    tick();
    vecs++;
    if (cut_req_o !== 1'b1) begin
      errs++;
      $display("FAIL pause_cut_rise: cut=%b, want 1", cut_req_o);
    end
    cut_done_i = 1'b1;
    tick();
    cut_done_i = 1'b0;
    vecs++;
    if (finish_o !== 1'b1 || slice_cnt_o !== 5'd1 || cut_req_o !== 1'b0) begin
      errs++;
      $display("FAIL pause_cut_end: fin=%b cnt=%0d cut=%b, want 1 1 0", finish_o, slice_cnt_o, cut_req_o);
    end
  endtask

  task automatic test_reset_midjob();
    start_job(5, 2);
    for (int s = 0; s < 2; s++) begin
      repeat (2) tick();
      pulse_dist(100);
      wait_req(1'b0, "rst_move_req");
      repeat (2) tick();
      move_done_i = 1'b1;
      tick();
      move_done_i = 1'b0;
      wait_req(1'b1, "rst_cut_req");
      if (s == 0) begin
        cut_done_i = 1'b1;
        tick();
        cut_done_i = 1'b0;
      end
    end
    vecs++;
    if (slice_cnt_o !== 5'd1) begin
      errs++;
      $display("FAIL pre_reset_cnt: got %0d want 1", slice_cnt_o);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (cut_req_o !== 1'b0 || slice_cnt_o !== 5'd0 || busy_o !== 1'b0 || move_steps_o !== 16'd0) begin
      errs++;
      $display("FAIL async_reset: cut=%b cnt=%0d busy=%b steps=%0d, want 0 0 0 0",
               cut_req_o, slice_cnt_o, busy_o, move_steps_o);
    end
    tick();
    rst = 1'b0;
    tick();
    dist_seq = '{200};
    test_job(7, 1, 1, 1'b0);
  endtask

  task automatic test_zero_config();
    start_job(0, 3);
    vecs++;
    if (err_o !== 1'b1 || finish_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL zero_len: err=%b fin=%b busy=%b, want 1 0 0", err_o, finish_o, busy_o);
    end
    start_job(4, 0);
    vecs++;
    if (finish_o !== 1'b1 || err_o !== 1'b0 || short_o !== 1'b0) begin
      errs++;
      $display("FAIL zero_total: fin=%b err=%b sh=%b, want 1 0 0", finish_o, err_o, short_o);
    end
    start_job(0, 0);
    vecs++;
    if (err_o !== 1'b1 || finish_o !== 1'b0) begin
      errs++;
      $display("FAIL zero_both: err=%b fin=%b, want 1 0", err_o, finish_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_config();
    test_timeout();
    test_pause_cut();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
